uart_operand_rx: RTL and testbench

//   UART receive front end feeding the multiply core: oversamples uart_rx, deserialises
//   8N1 bytes and assembles two consecutive bytes into operand A (first) and operand B
//   (second). Raises frames_received when the pair is complete; holds operands until acked.

---
 rtl/uart_operand_rx.sv | 208 ++++++++++++++++++++
 tb/tb_uart_operand_rx.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_operand_rx.sv
// uart_operand_rx: UART receive front end for the multiply core.
// Oversamples uart_rx, deserialises bytes and pairs consecutive good bytes
// into operand_a (first) and operand_b (second). frames_received holds the
// pair until frames_ack. The bit period follows freq_control.
// Optional build macro: RX_PARITY_EN selects 8E1 framing; undefined gives 8N1.
//
// Handshake: frames_received is a level "valid". frames_ack is a single-cycle
// "ready/consume" pulse that only takes effect while frames_received=1.
// The operands are stable for as long as frames_received=1.
module uart_operand_rx #(
  parameter int OS_DIV  = 4,
  parameter int OS_RATE = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_enable,
  input  logic [1:0] freq_control,
  input  logic       uart_rx,
  input  logic       frames_ack,
  output logic [7:0] operand_a,
  output logic [7:0] operand_b,
  output logic       frames_received,
  output logic       frame_error,
  output logic       overrun
);

  localparam int DIV_W  = $clog2(8 * OS_DIV);
  localparam int TICK_W = $clog2(OS_RATE);

`ifdef RX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} rx_state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} rx_state_t;
`endif

  rx_state_t         state;
  rx_state_t         state_next;

  logic              rx_s1;
  logic              rx_s2;
  logic              rx_prev;
  logic [1:0]        fc_q;
  logic [DIV_W-1:0]  div_cnt;
  logic [DIV_W-1:0]  div_last;
  logic [TICK_W-1:0] tick_cnt;
  logic [2:0]        bit_cnt;
  logic [7:0]        shift_q;
  logic              pair_cnt;
`ifdef RX_PARITY_EN
  logic              parity_err;
`endif

  logic              start_edge;
  logic              fc_changed;
  logic              tick;
  logic              sample_pt;
  logic              stop_sample;
  logic              byte_good;
  logic              byte_bad;

  // Two-flop synchroniser plus previous value for falling-edge detection.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
      fc_q    <= 2'b00;
    end else begin
      rx_s1   <= uart_rx;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      fc_q    <= freq_control;
    end
  end

  // Terminal count of the oversample divider for the selected rate.
  always_comb begin
    case (freq_control)
      2'b01:   div_last = DIV_W'(OS_DIV - 1);
      2'b10:   div_last = DIV_W'(2 * OS_DIV - 1);
      2'b11:   div_last = DIV_W'(4 * OS_DIV - 1);
      default: div_last = DIV_W'(8 * OS_DIV - 1);
    endcase
  end

  // Decoded strobes: start edge, tick, sample point and byte outcome.
  always_comb begin
    start_edge  = (state == S_IDLE) && rx_prev && !rx_s2;
    fc_changed  = (fc_q != freq_control);
    tick        = (div_cnt == div_last);
    if (state == S_START)
      sample_pt = tick && (tick_cnt == TICK_W'(OS_RATE / 2 - 1));
    else
      sample_pt = tick && (tick_cnt == TICK_W'(OS_RATE - 1));
    stop_sample = rx_enable && (state == S_STOP) && sample_pt;
`ifdef RX_PARITY_EN
    byte_good   = stop_sample && rx_s2 && !parity_err;
`else
    byte_good   = stop_sample && rx_s2;
`endif
    byte_bad    = stop_sample && !byte_good;
  end

  // Free-running oversample divider, realigned on start edge or rate change.
  always_ff @(posedge clk) begin
    if (!reset)
      div_cnt <= '0;
    else if (!rx_enable || start_edge || fc_changed || tick)
      div_cnt <= '0;
    else
      div_cnt <= div_cnt + 1'b1;
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!reset)
      state <= S_IDLE;
    else
      state <= state_next;
  end

  // FSM next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:   if (start_edge) state_next = S_START;
      S_START:  if (sample_pt) state_next = rx_s2 ? S_IDLE : S_DATA;
`ifdef RX_PARITY_EN
      S_DATA:   if (sample_pt && (bit_cnt == 3'd7)) state_next = S_PARITY;
      S_PARITY: if (sample_pt) state_next = S_STOP;
`else
      S_DATA:   if (sample_pt && (bit_cnt == 3'd7)) state_next = S_STOP;
`endif
      S_STOP:   if (sample_pt) state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
    if (!rx_enable)
      state_next = S_IDLE;
  end

  // Tick/bit counters and data shift register within a frame.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift_q  <= '0;
    end else if (!rx_enable || state == S_IDLE) begin
      tick_cnt <= '0;
      bit_cnt  <= '0;
    end else if (tick) begin
      tick_cnt <= sample_pt ? '0 : tick_cnt + 1'b1;
      if (sample_pt && state == S_DATA) begin
        shift_q <= {rx_s2, shift_q[7:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

`ifdef RX_PARITY_EN
  // Even parity: the parity bit must make the total count of ones even.
  always_ff @(posedge clk) begin
    if (!reset)
      parity_err <= 1'b0;
    else if (start_edge)
      parity_err <= 1'b0;
    else if (state == S_PARITY && sample_pt)
      parity_err <= (^shift_q) ^ rx_s2;
  end
`endif

  // Pair assembly, hand-off flags and error reporting.
  always_ff @(posedge clk) begin
    if (!reset) begin
      operand_a       <= '0;
      operand_b       <= '0;
      pair_cnt        <= 1'b0;
      frames_received <= 1'b0;
      frame_error     <= 1'b0;
      overrun         <= 1'b0;
    end else if (!rx_enable) begin
      pair_cnt        <= 1'b0;
      frames_received <= 1'b0;
      frame_error     <= 1'b0;
      overrun         <= 1'b0;
    end else begin
      frame_error <= byte_bad;
      if (frames_ack && frames_received) begin
        frames_received <= 1'b0;
        overrun         <= 1'b0;
      end
      if (byte_bad) begin
        pair_cnt <= 1'b0;
      end else if (byte_good) begin
        if (frames_received && !frames_ack) begin
          overrun <= 1'b1;
        end else if (!pair_cnt) begin
          operand_a <= shift_q;
          pair_cnt  <= 1'b1;
        end else begin
          operand_b       <= shift_q;
          pair_cnt        <= 1'b0;
          frames_received <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_operand_rx.sv
// tb_uart_operand_rx: directed bench for uart_operand_rx (OS_DIV=4, OS_RATE=16).
// Build with RX_PARITY_EN defined to exercise 8E1 framing.
module tb_uart_operand_rx;

  logic       clk;
  logic       reset;
  logic       rx_enable;
  logic [1:0] freq_control;
  logic       uart_rx;
  logic       frames_ack;
  logic [7:0] operand_a;
  logic [7:0] operand_b;
  logic       frames_received;
  logic       frame_error;
  logic       overrun;

  int checks   = 0;
  int failures = 0;
  int fe_cnt   = 0;

  uart_operand_rx #(.OS_DIV(4), .OS_RATE(16)) dut (
    .clk             (clk),
    .reset           (reset),
    .rx_enable       (rx_enable),
    .freq_control    (freq_control),
    .uart_rx         (uart_rx),
    .frames_ack      (frames_ack),
    .operand_a       (operand_a),
    .operand_b       (operand_b),
    .frames_received (frames_received),
    .frame_error     (frame_error),
    .overrun         (overrun)
  );

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count cycles with frame_error high, sampled away from the active edge.
  always @(negedge clk) begin
    if (frame_error) fe_cnt++;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic val, input int n);
    @(negedge clk);
    uart_rx = val;
    repeat (n - 1) @(negedge clk);
  endtask

  task automatic idle(input int n);
    hold(1'b1, n);
  endtask

  // Start bit plus the first nbits data bits, LSB first.
  task automatic send_bits(input logic [7:0] data, input int cpb, input int nbits);
    hold(1'b0, cpb);
    for (int i = 0; i < nbits; i++) hold(data[i], cpb);
  endtask

  task automatic send_frame(input logic [7:0] data, input int cpb,
                            input logic stop_val, input logic par_flip);
    send_bits(data, cpb, 8);
`ifdef RX_PARITY_EN
    hold((^data) ^ par_flip, cpb);
`else
    if (par_flip) hold(1'b1, 1);
`endif
    hold(stop_val, cpb);
  endtask

  task automatic ack;
    @(negedge clk);
    frames_ack = 1'b1;
    @(negedge clk);
    frames_ack = 1'b0;
  endtask

  initial begin
    int fe_base;
    reset        = 1'b0;
    rx_enable    = 1'b1;
    freq_control = 2'b01;
    uart_rx      = 1'b1;
    frames_ack   = 1'b0;
    repeat (5) @(negedge clk);

    // Reset state.
    check("rst_a", operand_a, 8'h00);
    check("rst_b", operand_b, 8'h00);
    check("rst_fr", {7'd0, frames_received}, 8'd0);
    check("rst_fe", {7'd0, frame_error}, 8'd0);
    check("rst_ov", {7'd0, overrun}, 8'd0);
    reset = 1'b1;
    idle(20);

    // Basic pair with exact frames_received timing.
    send_frame(8'h5A, 64, 1'b1, 1'b0);
    idle(20);
    check("t1_a_only", operand_a, 8'h5A);
    send_bits(8'hA5, 64, 8);
`ifdef RX_PARITY_EN
    hold(^8'hA5, 64);
`endif
    @(negedge clk);
    uart_rx = 1'b1;
    repeat (34) @(negedge clk);
    check("t1_fr_before", {7'd0, frames_received}, 8'd0);
    @(negedge clk);
    check("t1_fr_after", {7'd0, frames_received}, 8'd1);
    repeat (29) @(negedge clk);
    check("t1_a", operand_a, 8'h5A);
    check("t1_b", operand_b, 8'hA5);
    check("t1_fe", fe_cnt[7:0], 8'd0);
    check("t1_ov", {7'd0, overrun}, 8'd0);
    ack();
    check("t1_ack_fr", {7'd0, frames_received}, 8'd0);

    // Slowest-but-one rate, then bytes sent too fast for it.
    freq_control = 2'b11;
    idle(50);
    send_frame(8'h00, 256, 1'b1, 1'b0);
    idle(40);
    send_frame(8'hFF, 256, 1'b1, 1'b0);
    idle(40);
    check("t2_a", operand_a, 8'h00);
    check("t2_b", operand_b, 8'hFF);
    check("t2_fr", {7'd0, frames_received}, 8'd1);
    ack();
    idle(40);
    send_frame(8'h00, 64, 1'b1, 1'b0);
    send_frame(8'hFF, 64, 1'b1, 1'b0);
    idle(1600);
    check("t2_mismatch_fr", {7'd0, frames_received}, 8'd0);
    rx_enable = 1'b0;
    repeat (4) @(negedge clk);
    check("t2_dis_fr", {7'd0, frames_received}, 8'd0);
    rx_enable    = 1'b1;
    freq_control = 2'b01;
    idle(40);

    // Short low glitch is rejected; following pair is clean.
    fe_base = fe_cnt;
    hold(1'b0, 20);
    idle(60);
    check("t3_glitch_fr", {7'd0, frames_received}, 8'd0);
    check("t3_glitch_fe", 8'(fe_cnt - fe_base), 8'd0);
    send_frame(8'h12, 64, 1'b1, 1'b0);
    idle(20);
    send_frame(8'h34, 64, 1'b1, 1'b0);
    idle(20);
    check("t3_a", operand_a, 8'h12);
    check("t3_b", operand_b, 8'h34);
    check("t3_fr", {7'd0, frames_received}, 8'd1);
    ack();
    idle(20);

    // Bad stop bit resets the pair counter.
    fe_base = fe_cnt;
    send_frame(8'h44, 64, 1'b1, 1'b0);
    idle(20);
    send_frame(8'h11, 64, 1'b0, 1'b0);
    idle(20);
    check("t4_fe_once", 8'(fe_cnt - fe_base), 8'd1);
    check("t4_fr_none", {7'd0, frames_received}, 8'd0);
    send_frame(8'h22, 64, 1'b1, 1'b0);
    idle(20);
    send_frame(8'h33, 64, 1'b1, 1'b0);
    idle(20);
    check("t4_a", operand_a, 8'h22);
    check("t4_b", operand_b, 8'h33);
    check("t4_fr", {7'd0, frames_received}, 8'd1);

    // Overrun while the pair is held.
    send_frame(8'h77, 64, 1'b1, 1'b0);
    idle(20);
    check("t5_ov", {7'd0, overrun}, 8'd1);
    check("t5_a", operand_a, 8'h22);
    check("t5_b", operand_b, 8'h33);
    check("t5_fr", {7'd0, frames_received}, 8'd1);
    ack();
    check("t5_ack_fr", {7'd0, frames_received}, 8'd0);
    check("t5_ack_ov", {7'd0, overrun}, 8'd0);
    idle(20);

    // Reset in the middle of bit 4 of the second byte.
    send_frame(8'h5A, 64, 1'b1, 1'b0);
    idle(20);
    check("t6_a_first", operand_a, 8'h5A);
    send_bits(8'hA5, 64, 4);
    hold(1'b0, 32);
    reset   = 1'b0;
    uart_rx = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_rst_a", operand_a, 8'h00);
    check("t6_rst_b", operand_b, 8'h00);
    check("t6_rst_fr", {7'd0, frames_received}, 8'd0);
    check("t6_rst_fe", {7'd0, frame_error}, 8'd0);
    check("t6_rst_ov", {7'd0, overrun}, 8'd0);
    reset = 1'b1;
    idle(40);
    fe_base = fe_cnt;
    send_frame(8'h5A, 64, 1'b1, 1'b0);
    idle(20);
    send_frame(8'hA5, 64, 1'b1, 1'b0);
    idle(20);
    check("t6_a", operand_a, 8'h5A);
    check("t6_b", operand_b, 8'hA5);
    check("t6_fr", {7'd0, frames_received}, 8'd1);
    check("t6_fe", 8'(fe_cnt - fe_base), 8'd0);
    ack();
    idle(20);

`ifdef RX_PARITY_EN
    // Wrong parity discards the byte.
    fe_base = fe_cnt;
    send_frame(8'h5A, 64, 1'b1, 1'b1);
    idle(20);
    check("t7_fe", 8'(fe_cnt - fe_base), 8'd1);
    send_frame(8'h3C, 64, 1'b1, 1'b0);
    idle(20);
    check("t7_a", operand_a, 8'h3C);
    check("t7_fr", {7'd0, frames_received}, 8'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
